// File: rtl/uart_led_reporter.sv
// uart_led_reporter: sends "R<r>G<g>B<b>\r\n" over an 8N1 UART line whenever the
// LED state changes, on request, and once after reset.
`timescale 1ns/1ps
module uart_led_reporter #(
    parameter int unsigned CLK_DIV = 625
) (
    input  logic       hw_clk,
    input  logic       reset,
    input  logic [2:0] led_state,
    input  logic       report_req,
    output logic       uarttx,
    output logic       busy,
    output logic [7:0] msg_count
);

    localparam int unsigned BaudW = $clog2(CLK_DIV);
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic [2:0]       snap_q, snap_d;
    logic [2:0]       last_q, last_d;
    logic             req_pend_q, req_pend_d;
    logic             init_pend_q, init_pend_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [7:0] cur_byte;
    logic       baud_done;
    logic       trigger;

    assign baud_done = (baud_q == BaudMax);
    assign trigger   = (led_state != last_q) | report_req | req_pend_q | init_pend_q;

    // Message byte selected by the byte index; digits come from the frozen snapshot.
    always_comb begin
        cur_byte = 8'h0A;
        case (byte_q)
            3'd0:    cur_byte = 8'h52;
            3'd1:    cur_byte = {7'b0011000, snap_q[2]};
            3'd2:    cur_byte = 8'h47;
            3'd3:    cur_byte = {7'b0011000, snap_q[1]};
            3'd4:    cur_byte = 8'h42;
            3'd5:    cur_byte = {7'b0011000, snap_q[0]};
            3'd6:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // Next-state logic: trigger detection, bit timing and frame sequencing.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        snap_d      = snap_q;
        last_d      = last_q;
        req_pend_d  = req_pend_q;
        init_pend_d = init_pend_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;

        // Requests arriving mid-message collapse into a single follow-up.
        if (state_q != StIdle && report_req) req_pend_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    snap_d      = led_state;
                    last_d      = led_state;
                    req_pend_d  = 1'b0;
                    init_pend_d = 1'b0;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                    byte_d      = 3'd0;
                    bit_d       = 3'd0;
                    baud_d      = '0;
                    state_d     = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_d];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q != 3'd7) begin
                        // Next start bit follows the stop bit with no gap.
                        byte_d  = byte_q + 3'd1;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        busy_d  = 1'b0;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any partial frame and arms the initial report.
    always_ff @(posedge hw_clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            byte_q      <= 3'd0;
            snap_q      <= 3'd0;
            last_q      <= 3'd0;
            req_pend_q  <= 1'b0;
            init_pend_q <= 1'b1;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            snap_q      <= snap_d;
            last_q      <= last_d;
            req_pend_q  <= req_pend_d;
            init_pend_q <= init_pend_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign uarttx    = tx_q;
    assign busy      = busy_q;
    assign msg_count = cnt_q;

endmodule

// File: tb/tb_uart_led_reporter.sv
// Bench for uart_led_reporter: message-level reference model compared every cycle,
// a passive UART decoder, directed scenarios with literal byte expectations, and a
// randomized phase.
`timescale 1ns/1ps
module tb_uart_led_reporter;

    localparam int D       = 2;
    localparam int MSG_CYC = 80 * D;

    logic       hw_clk     = 1'b0;
    logic       reset      = 1'b1;
    logic [2:0] led_state  = 3'b000;
    logic       report_req = 1'b0;
    logic       uarttx;
    logic       busy;
    logic [7:0] msg_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic       m_tx;
    logic       m_busy;
    logic       m_req;
    logic       m_init;
    logic [2:0] m_last;
    int         m_count;
    logic       m_bits[$];

    logic [7:0] rx_q[$];

    uart_led_reporter #(.CLK_DIV(D)) dut (
        .hw_clk     (hw_clk),
        .reset      (reset),
        .led_state  (led_state),
        .report_req (report_req),
        .uarttx     (uarttx),
        .busy       (busy),
        .msg_count  (msg_count)
    );

    always #5 hw_clk = ~hw_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int i, input logic [2:0] s);
        logic [7:0] line [8];
        line = '{8'h52, s[2] ? 8'h31 : 8'h30, 8'h47, s[1] ? 8'h31 : 8'h30,
                 8'h42, s[0] ? 8'h31 : 8'h30, 8'h0D, 8'h0A};
        return line[i];
    endfunction

    task automatic m_reset();
        m_tx    = 1'b1;
        m_busy  = 1'b0;
        m_req   = 1'b0;
        m_init  = 1'b1;
        m_last  = 3'b000;
        m_count = 0;
        m_bits.delete();
    endtask

    // One clock edge of the model: a message is a precomputed per-cycle waveform.
    task automatic m_step();
        logic [7:0] b;
        logic       v;
        if (!m_busy) begin
            if (led_state != m_last || report_req || m_req || m_init) begin
                m_last = led_state;
                m_req  = 1'b0;
                m_init = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    b = msg_byte(i, led_state);
                    for (int k = 0; k < 10; k++) begin
                        v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                        for (int c = 0; c < D; c++) m_bits.push_back(v);
                    end
                end
                m_tx   = m_bits.pop_front();
                m_busy = 1'b1;
            end
        end else begin
            if (report_req) m_req = 1'b1;
            if (m_bits.size() == 0) begin
                m_busy  = 1'b0;
                m_count = (m_count + 1) % 256;
                m_tx    = 1'b1;
            end else begin
                m_tx = m_bits.pop_front();
            end
        end
    endtask

    initial begin : model
        m_reset();
        forever begin
            @(posedge hw_clk or posedge reset);
            if (reset) m_reset();
            else m_step();
        end
    end

    initial begin : compare
        forever begin
            @(posedge hw_clk);
            #1;
            chk("uarttx", uarttx, m_tx);
            chk("busy", busy, m_busy);
            chk("msg_count", msg_count, m_count[7:0]);
        end
    end

    initial begin : decoder
        logic       prev;
        logic       abort;
        logic       v0;
        logic       v9;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(posedge hw_clk);
            #1;
            if (reset) begin
                prev = 1'b1;
            end else if (prev && !uarttx) begin
                abort = 1'b0;
                b     = 8'h00;
                v0    = 1'b0;
                v9    = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < ((k == 0) ? D / 2 : D); j++) begin
                        @(posedge hw_clk);
                        #1;
                        if (reset) abort = 1'b1;
                        if (abort) break;
                    end
                    if (abort) break;
                    if (k == 0) v0 = uarttx;
                    else if (k == 9) v9 = uarttx;
                    else b[k-1] = uarttx;
                end
                if (!abort) begin
                    chk("frame_start", v0, 1'b0);
                    chk("frame_stop", v9, 1'b1);
                    rx_q.push_back(b);
                end
                prev = abort ? 1'b1 : uarttx;
            end else begin
                prev = uarttx;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge hw_clk);
    endtask

    task automatic pulse_req();
        report_req = 1'b1;
        @(negedge hw_clk);
        report_req = 1'b0;
    endtask

    task automatic wait_busy(input logic v, input int limit, input string name);
        int i;
        i = 0;
        while (busy !== v && i < limit) begin
            @(negedge hw_clk);
            i++;
        end
        if (busy !== v) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout, busy=%0b, expected %0b", name, busy, v);
        end
    endtask

    // Expected line given as 8 bytes, first byte in the top bits.
    task automatic expect_msg(input string name, input logic [63:0] want);
        chk({name, "_len"}, rx_q.size(), 8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            chk(name, rx_q[i], want[63-8*i -: 8]);
        end
        rx_q.delete();
    endtask

    initial begin : stim
        int blen;

        // 1: reset state and initial report
        cyc(3);
        chk("rst_tx", uarttx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", msg_count, 8'd0);
        reset = 1'b0;
        wait_busy(1'b1, 4, "t1_start");
        blen = 0;
        while (busy === 1'b1 && blen < MSG_CYC + 10) begin
            blen++;
            @(negedge hw_clk);
        end
        chk("t1_busy_len", blen, MSG_CYC);
        expect_msg("t1_bytes", 64'h52_30_47_30_42_30_0D_0A);
        chk("t1_cnt", msg_count, 8'd1);

        // 2: change while idle starts on the sampling edge
        cyc(3);
        led_state = 3'b101;
        @(negedge hw_clk);
        chk("t2_tx_low", uarttx, 1'b0);
        chk("t2_busy", busy, 1'b1);
        wait_busy(1'b0, MSG_CYC + 10, "t2_end");
        expect_msg("t2_bytes", 64'h52_31_47_30_42_31_0D_0A);
        chk("t2_cnt", msg_count, 8'd2);

        // 3: changes while busy give one follow-up; a reverted change gives none
        cyc(3);
        pulse_req();
        cyc(20);
        led_state = 3'b011;
        cyc(20);
        led_state = 3'b010;
        wait_busy(1'b0, MSG_CYC + 10, "t3_end");
        expect_msg("t3_first", 64'h52_31_47_30_42_31_0D_0A);
        @(negedge hw_clk);
        chk("t3_follow_busy", busy, 1'b1);
        chk("t3_follow_tx", uarttx, 1'b0);
        wait_busy(1'b0, MSG_CYC + 10, "t3_follow_end");
        expect_msg("t3_follow", 64'h52_30_47_31_42_30_0D_0A);
        chk("t3_cnt", msg_count, 8'd4);
        cyc(3);
        led_state = 3'b001;
        wait_busy(1'b1, 4, "t3_rev_start");
        cyc(20);
        led_state = 3'b010;
        cyc(20);
        led_state = 3'b001;
        wait_busy(1'b0, MSG_CYC + 10, "t3_rev_end");
        expect_msg("t3_rev", 64'h52_30_47_30_42_31_0D_0A);
        cyc(2 * D + 10);
        chk("t3_no_follow", busy, 1'b0);
        chk("t3_cnt2", msg_count, 8'd5);

        // 4: request while idle repeats; three while busy coalesce into one
        cyc(3);
        pulse_req();
        wait_busy(1'b0, MSG_CYC + 10, "t4_end");
        expect_msg("t4_repeat", 64'h52_30_47_30_42_31_0D_0A);
        chk("t4_cnt", msg_count, 8'd6);
        cyc(3);
        pulse_req();
        cyc(10);
        pulse_req();
        cyc(30);
        pulse_req();
        cyc(30);
        pulse_req();
        wait_busy(1'b0, MSG_CYC + 10, "t4_multi_end");
        expect_msg("t4_multi", 64'h52_30_47_30_42_31_0D_0A);
        @(negedge hw_clk);
        chk("t4_extra_busy", busy, 1'b1);
        wait_busy(1'b0, MSG_CYC + 10, "t4_extra_end");
        expect_msg("t4_extra", 64'h52_30_47_30_42_31_0D_0A);
        cyc(10);
        chk("t4_only_one", busy, 1'b0);
        chk("t4_cnt2", msg_count, 8'd8);

        // 5: reset in byte 3 bit 4 (message bit 35)
        cyc(3);
        pulse_req();
        cyc(35 * D);
        reset = 1'b1;
        #1;
        chk("t5_tx", uarttx, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_cnt", msg_count, 8'd0);
        rx_q.delete();
        led_state = 3'b110;
        cyc(3);
        reset = 1'b0;
        wait_busy(1'b1, 4, "t5_restart");
        wait_busy(1'b0, MSG_CYC + 10, "t5_end");
        expect_msg("t5_fresh", 64'h52_31_47_31_42_30_0D_0A);
        chk("t5_cnt2", msg_count, 8'd1);

        // 6: counter wrap after 256 messages since reset
        for (int i = 0; i < 255; i++) begin
            cyc(2);
            pulse_req();
            wait_busy(1'b0, MSG_CYC + 10, "t6_end");
        end
        rx_q.delete();
        chk("t6_wrap", msg_count, 8'd0);

        // 7: randomized LED changes, requests and occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge hw_clk);
            report_req = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) led_state = 3'($urandom);
            if (c == 2000 || $urandom_range(0, 1499) == 0) begin
                reset = 1'b1;
                cyc(2);
                reset = 1'b0;
            end
        end
        report_req = 1'b0;
        wait_busy(1'b0, 2 * MSG_CYC + 10, "t7_drain");
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
